// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit command sequencer: opcodes, FSM state
// encoding and the capture bundle written back on each executed command.
package lu_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NOT  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_READ = 3'd5;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [3:0] acc;
        logic [3:0] data;
        logic       err;
    } capture_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational 4-bit logic unit: {s1,s0} selects AND, OR, XOR or NOT(x).
module logic_unit (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       s1,
    input  logic       s0,
    output logic [3:0] f
);

    always_comb begin
        f = 4'd0;
        case ({s1, s0})
            2'b00:   f = x & y;
            2'b01:   f = x | y;
            2'b10:   f = x ^ y;
            default: f = ~x;
        endcase
    end

endmodule

// File: rtl/lu_op_sequencer.sv
// Sequences one command at a time through logic_unit against a 4-bit accumulator,
// returning each result over a valid/ready handshake.
module lu_op_sequencer
    import lu_pkg::*;
#(
    parameter logic [3:0] ACC_INIT = 4'b0000,
    parameter int         CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_data,
    output logic             res_err,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0] state;
    logic [2:0] op_q;
    logic [3:0] data_q;
    logic [3:0] acc;
    logic [3:0] lu_f;
    capture_t   cap;

    logic_unit u_lu (
        .x  (acc),
        .y  (data_q),
        .s1 (op_q[1]),
        .s0 (op_q[0]),
        .f  (lu_f)
    );

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == RESP);

    // Illegal opcodes report the untouched accumulator so the consumer still sees context.
    always_comb begin
        cap.acc  = acc;
        cap.data = acc;
        cap.err  = 1'b0;
        case (op_q)
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                cap.acc  = lu_f;
                cap.data = lu_f;
            end
            OP_LOAD: begin
                cap.acc  = data_q;
                cap.data = data_q;
            end
            OP_READ: cap.data = acc;
            default: cap.err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            data_q   <= 4'd0;
            acc      <= ACC_INIT;
            res_data <= 4'd0;
            res_err  <= 1'b0;
            res_zero <= 1'b1;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        data_q  <= cmd_data;
                        res_err <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    acc      <= cap.acc;
                    res_data <= cap.data;
                    res_err  <= cap.err;
                    res_zero <= (cap.data == 4'd0);
                    state    <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_op_sequencer.sv
// Directed bench for lu_op_sequencer: a transaction-level accumulator model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_lu_op_sequencer;

    localparam int         CNT_W    = 2;
    localparam logic [3:0] ACC_INIT = 4'b0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [3:0]       cmd_data = 4'd0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [3:0]       res_data;
    logic             res_err;
    logic             res_zero;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    lu_op_sequencer #(.ACC_INIT(ACC_INIT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_zero  (res_zero),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    // Transaction model: a command is busy for one execute cycle, then its result is offered.
    bit               m_busy = 0;
    bit               m_offered = 0;
    logic [3:0]       m_acc = ACC_INIT;
    logic [3:0]       m_data = 4'd0;
    logic             m_err = 1'b0;
    logic             m_zero = 1'b1;
    logic [CNT_W-1:0] m_cnt = '0;
    logic [3:0]       p_acc, p_data;
    logic             p_err;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_offered = 0; m_acc = ACC_INIT;
            m_data = 4'd0; m_err = 1'b0; m_zero = 1'b1; m_cnt = '0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_offered = 0; m_err = 1'b0;
                p_err = 1'b0; p_acc = m_acc;
                case (cmd_op)
                    3'd0: p_acc = m_acc & cmd_data;
                    3'd1: p_acc = m_acc | cmd_data;
                    3'd2: p_acc = m_acc ^ cmd_data;
                    3'd3: p_acc = ~m_acc;
                    3'd4: p_acc = cmd_data;
                    3'd5: p_acc = m_acc;
                    default: p_err = 1'b1;
                endcase
                p_data = p_acc;
            end
        end else if (!m_offered) begin
            m_offered = 1; m_acc = p_acc; m_data = p_data;
            m_err = p_err; m_zero = (p_data == 4'd0);
        end else if (res_ready) begin
            m_busy = 0; m_offered = 0; m_cnt = m_cnt + 1'b1;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cmd_ready", 8'(cmd_ready), 8'(!m_busy));
            checkOutput("res_valid", 8'(res_valid), 8'(m_busy && m_offered));
            checkOutput("res_data", 8'(res_data), 8'(m_data));
            checkOutput("res_err", 8'(res_err), 8'(m_err));
            checkOutput("res_zero", 8'(res_zero), 8'(m_zero));
            checkOutput("op_count", 8'(op_count), 8'(m_cnt));
        end
    end

    // Presents a command from a negedge and returns at the negedge after it is taken.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeoutFail("cmd accept");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(input logic [3:0] exp_data, input logic exp_err, input logic exp_zero,
                                input bit keep_ready, output int latency);
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) timeoutFail("res_valid wait");
        latency = n + 1;
        checkOutput("lit res_data", 8'(res_data), 8'(exp_data));
        checkOutput("lit res_err", 8'(res_err), 8'(exp_err));
        checkOutput("lit res_zero", 8'(res_zero), 8'(exp_zero));
        @(negedge clk);
        if (!keep_ready) res_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        @(negedge clk);
        @(negedge clk);
        checking = 1;
        checkOutput("reset cmd_ready", 8'(cmd_ready), 8'd1);
        checkOutput("reset res_valid", 8'(res_valid), 8'd0);
        checkOutput("reset res_data", 8'(res_data), 8'd0);
        checkOutput("reset res_zero", 8'(res_zero), 8'd1);
        checkOutput("reset op_count", 8'(op_count), 8'd0);
        rst = 1'b0;

        $display("[TB] read after reset");
        applyStimulus(3'd5, 4'b0000);
        waitResponse(4'b0000, 1'b0, 1'b1, 0, lat);
        checkOutput("op_count after first read", 8'(op_count), 8'd1);

        $display("[TB] logic chain with stalled consumer");
        applyStimulus(3'd4, 4'b1011);
        waitResponse(4'b1011, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd0, 4'b1100);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) timeoutFail("AND result");
        cmd_valid = 1'b1;
        cmd_op    = 3'd1;
        cmd_data  = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall res_valid", 8'(res_valid), 8'd1);
            checkOutput("stall res_data", 8'(res_data), 8'b1000);
            checkOutput("stall cmd_ready", 8'(cmd_ready), 8'd0);
            checkOutput("stall op_count", 8'(op_count), 8'd2);
            @(negedge clk);
        end
        waitResponse(4'b1000, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd1, 4'b0011);
        waitResponse(4'b1011, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd2, 4'b1100);
        waitResponse(4'b0111, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd3, 4'b1111);
        waitResponse(4'b1000, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd5, 4'b0000);
        waitResponse(4'b1000, 1'b0, 1'b0, 0, lat);

        $display("[TB] illegal opcode");
        applyStimulus(3'd4, 4'b0101);
        waitResponse(4'b0101, 1'b0, 1'b0, 0, lat);
        applyStimulus(3'd6, 4'b1010);
        waitResponse(4'b0101, 1'b1, 1'b0, 0, lat);
        applyStimulus(3'd5, 4'b0000);
        checkOutput("err cleared on accept", 8'(res_err), 8'd0);
        waitResponse(4'b0101, 1'b0, 1'b0, 0, lat);

        $display("[TB] reset during execute");
        applyStimulus(3'd4, 4'b1111);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset res_valid", 8'(res_valid), 8'd0);
        checkOutput("midreset cmd_ready", 8'(cmd_ready), 8'd1);
        checkOutput("midreset op_count", 8'(op_count), 8'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("no late result", 8'(res_valid), 8'd0);
        end
        applyStimulus(3'd5, 4'b0000);
        waitResponse(ACC_INIT, 1'b0, 1'b1, 0, lat);

        $display("[TB] counter wrap and latency");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'd5, 4'b0000);
            waitResponse(ACC_INIT, 1'b0, 1'b1, 1, lat);
            checkOutput("read latency", 8'(lat), 8'd2);
            checkOutput("wrap op_count", 8'(op_count), 8'((i + 1) % 4));
        end
        res_ready = 1'b0;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
